// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbitration of four writeback requesters onto two
// register file write ports, with same-register conflict deferral and registered outputs.
module regfile_wb_arbiter #(
    parameter int NREQ = 4,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [5*NREQ-1:0] req_reg,
    input  logic [32*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              wen0,
    output logic [4:0]        wreg0,
    output logic [31:0]       wdata0,
    output logic              wen1,
    output logic [4:0]        wreg1,
    output logic [31:0]       wdata1,
    output logic [CNTW-1:0]   conflict_cnt
);
    logic [4:0]  regs  [NREQ];
    logic [31:0] datas [NREQ];
    logic [1:0]  rr_ptr, idx, a_idx, b_idx;
    logic        a_found, b_found, defer, wa, wb;
    logic [NREQ-1:0] grant;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign regs[i]  = req_reg[5*i +: 5];
        assign datas[i] = req_data[32*i +: 32];
    end

    // Slot B skips requesters that collide with slot A's non-zero register; those are deferred.
    always_comb begin
        a_found = 1'b0;
        b_found = 1'b0;
        a_idx   = rr_ptr;
        b_idx   = rr_ptr;
        defer   = 1'b0;
        idx     = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr_ptr + 2'(k);
            if (req_valid[idx]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_idx   = idx;
                end else if (!b_found) begin
                    if (regs[idx] == regs[a_idx] && regs[a_idx] != 5'd0) defer = 1'b1;
                    else begin
                        b_found = 1'b1;
                        b_idx   = idx;
                    end
                end
            end
        end
        grant = '0;
        if (a_found) grant[a_idx] = 1'b1;
        if (b_found) grant[b_idx] = 1'b1;
        req_ready = reset_n ? grant : '0;
        wa = a_found && regs[a_idx] != 5'd0;
        wb = b_found && regs[b_idx] != 5'd0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wen0         <= 1'b0;
            wreg0        <= '0;
            wdata0       <= '0;
            wen1         <= 1'b0;
            wreg1        <= '0;
            wdata1       <= '0;
            rr_ptr       <= '0;
            conflict_cnt <= '0;
        end else begin
            wen0 <= wa;
            wen1 <= wb;
            if (wa) begin
                wreg0  <= regs[a_idx];
                wdata0 <= datas[a_idx];
            end
            if (wb) begin
                wreg1  <= regs[b_idx];
                wdata1 <= datas[b_idx];
            end
            rr_ptr <= b_found ? b_idx + 2'd1 : a_found ? a_idx + 2'd1 : rr_ptr;
            if (defer && ~&conflict_cnt) conflict_cnt <= conflict_cnt + CNTW'(1);
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of grant order, write timing, x0 drops,
// conflict deferral, reset discard and counter saturation.
module tb_regfile_wb_arbiter;
    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   req_valid;
    logic [19:0]  req_reg;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         wen0, wen1;
    logic [4:0]   wreg0, wreg1;
    logic [31:0]  wdata0, wdata1;
    logic [15:0]  conflict_cnt;
    int passed = 0;
    int total  = 0;

    regfile_wb_arbiter #(.NREQ(4), .CNTW(16)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_reg(req_reg),
        .req_data(req_data), .req_ready(req_ready), .wen0(wen0), .wreg0(wreg0),
        .wdata0(wdata0), .wen1(wen1), .wreg1(wreg1), .wdata1(wdata1),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
        req_reg[5*i +: 5]   = r;
        req_data[32*i +: 32] = d;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 4'hF;
        req_reg   = '0;
        req_data  = '0;
        tick();
        @(negedge clk);
        chk("ready_in_reset", 32'(req_ready), 32'h0);
        tick();
        req_valid = 4'h0;
        reset_n   = 1'b1;
        // 1: idle
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_out", {26'd0, wen0, wen1, req_ready}, 32'h0);
            chk("idle_cnt", 32'(conflict_cnt), 32'h0);
        end
        // 2: single request on req 2
        set_req(2, 5'd5, 32'hDEADBEEF);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'h0;
        chk("single_wen0", 32'(wen0), 32'h1);
        chk("single_wreg0", 32'(wreg0), 32'd5);
        chk("single_wdata0", wdata0, 32'hDEADBEEF);
        chk("single_wen1", 32'(wen1), 32'h0);
        chk("single_rr", 32'(dut.rr_ptr), 32'd3);
        tick();
        chk("single_oneshot", 32'(wen0), 32'h0);
        chk("single_hold", wdata0, 32'hDEADBEEF);
        // 3: move pointer to 0, then four distinct requesters
        set_req(3, 5'd10, 32'h33);
        req_valid = 4'b1000;
        tick();
        chk("rr_to0", 32'(dut.rr_ptr), 32'd0);
        for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 32'h100 + 32'(i));
        req_valid = 4'hF;
        @(negedge clk);
        chk("four_ready_a", 32'(req_ready), 32'b0011);
        tick();
        req_valid = 4'b1100;
        chk("four_p0_a", {wen0, wreg0, wdata0[15:0]}, {1'b1, 5'd1, 16'h100});
        chk("four_p1_a", {wen1, wreg1, wdata1[15:0]}, {1'b1, 5'd2, 16'h101});
        @(negedge clk);
        chk("four_ready_b", 32'(req_ready), 32'b1100);
        tick();
        req_valid = 4'h0;
        chk("four_p0_b", {wen0, wreg0, wdata0[15:0]}, {1'b1, 5'd3, 16'h102});
        chk("four_p1_b", {wen1, wreg1, wdata1[15:0]}, {1'b1, 5'd4, 16'h103});
        chk("four_rr_wrap", 32'(dut.rr_ptr), 32'd0);
        // 4: same-register conflict
        set_req(0, 5'd7, 32'hA0);
        set_req(1, 5'd7, 32'hA1);
        req_valid = 4'b0011;
        @(negedge clk);
        chk("conf_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0010;
        chk("conf_cnt", 32'(conflict_cnt), 32'd1);
        chk("conf_p0", {wen0, wreg0, wdata0[15:0]}, {1'b1, 5'd7, 16'hA0});
        chk("conf_wen1", 32'(wen1), 32'h0);
        @(negedge clk);
        chk("conf_ready2", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'h0;
        chk("conf_p0_2", {wen0, wreg0, wdata0[15:0]}, {1'b1, 5'd7, 16'hA1});
        chk("conf_cnt2", 32'(conflict_cnt), 32'd1);
        // 5: x0 write dropped, rr_ptr = 3
        set_req(2, 5'd11, 32'hBB);
        req_valid = 4'b0100;
        tick();
        set_req(3, 5'd0, 32'h12345678);
        set_req(0, 5'd9, 32'h99);
        req_valid = 4'b1001;
        @(negedge clk);
        chk("x0_ready", 32'(req_ready), 32'b1001);
        tick();
        req_valid = 4'h0;
        chk("x0_wen0", 32'(wen0), 32'h0);
        chk("x0_wreg0_hold", 32'(wreg0), 32'd11);
        chk("x0_p1", {wen1, wreg1, wdata1[15:0]}, {1'b1, 5'd9, 16'h99});
        chk("x0_rr", 32'(dut.rr_ptr), 32'd1);
        // 6: reset discards a pending write
        set_req(0, 5'd4, 32'h44);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'h0;
        reset_n   = 1'b0;
        chk("rst_pending", 32'(wen0), 32'h1);
        tick();
        reset_n = 1'b1;
        chk("rst_wen", {30'd0, wen0, wen1}, 32'h0);
        chk("rst_rr", 32'(dut.rr_ptr), 32'd0);
        chk("rst_cnt", 32'(conflict_cnt), 32'd0);
        // saturation: two requesters on x7 defer one every cycle
        set_req(0, 5'd7, 32'h1);
        set_req(1, 5'd7, 32'h2);
        req_valid = 4'b0011;
        for (int c = 0; c < 3; c++) tick();
        chk("sat_cnt3", 32'(conflict_cnt), 32'd3);
        for (int c = 0; c < 65540; c++) tick();
        chk("sat_max", 32'(conflict_cnt), 32'hFFFF);
        tick();
        chk("sat_hold", 32'(conflict_cnt), 32'hFFFF);
        req_valid = 4'h0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's two write ports (wen0/wreg0/wdata0, wen1/wreg1/wdata1) between four writeback requesters: ALU, load unit, mul/div, CSR.
- Each cycle it grants up to two requests in round-robin order through a valid/ready handshake.
- Granted writes are registered and presented to the register file one cycle after the handshake.
- Sits between the execute/memory stage outputs and the register file write inputs.

Parameters:
- NREQ, 4, number of requesters. Fixed at 4; the pointer logic is sized for it.
- CNTW, 16, width of the saturating conflict-stall counter.

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous, active-low reset
- req_valid  input  4  per-requester write request
- req_reg  input  20  destination register; requester i uses bits [5i+4:5i]
- req_data  input  128  write data; requester i uses bits [32i+31:32i]
- req_ready  output  4  grant; a handshake completes when valid and ready are both high
- wen0  output  1  register file port 0 write enable
- wreg0  output  5  port 0 destination register
- wdata0  output  32  port 0 data
- wen1  output  1  register file port 1 write enable
- wreg1  output  5  port 1 destination register
- wdata1  output  32  port 1 data
- conflict_cnt  output  CNTW  saturating count of requests deferred because of a same-register conflict

Behaviour:
- Reset (reset_n low at posedge):
  - wen0 = wen1 = 0; wreg0/1 = 0; wdata0/1 = 0.
  - rr_ptr = 0; conflict_cnt = 0.
  - req_ready is forced to 0 while reset_n is low.
  - Reset mid-operation discards any registered, unwritten output; no write is issued on the following cycle.
- Grant (combinational, same cycle):
  - Scan requesters in order rr_ptr, rr_ptr+1, ... mod 4.
  - Slot A = first valid requester.
  - Slot B = next valid requester after A whose req_reg differs from A's, or where either register is x0.
  - req_ready is high only for A and B.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Output register (posedge after a handshake):
  - Slot A loads port 0 and slot B loads port 1.
  - wen = 1 only if the slot was granted and its reg != 0.
  - A granted x0 write completes the handshake but is dropped (wen = 0).
  - An unfilled port has wen = 0. wreg/wdata hold their previous values when wen = 0.
  - Latency: handshake in cycle N, wen high in cycle N+1 for exactly one cycle. The register file commits at the end of N+1 and its passthrough makes the data visible within N+1.
- Conflicts:
  - A valid requester skipped only because its reg equals slot A's non-zero reg waits; it is eligible again next cycle.
  - conflict_cnt increments by 1 per cycle in which at least one such deferral occurs, and saturates at all-ones.
  - Ports 0 and 1 therefore never target the same non-zero register in the same cycle.
- Round robin:
  - If any grant occurs, rr_ptr becomes (index of the last granted slot, B if present else A) + 1 mod 4.
  - Otherwise rr_ptr is unchanged.
  - Guarantee: a continuously valid requester is granted within 2 cycles when there are no conflicts, and within 4 cycles in the worst case.
- Back-pressure: none from the register file; every output register is consumed in its cycle.

Test Plan:
1. Reset, then no requests → wen0 = wen1 = 0, req_ready = 0000, conflict_cnt = 0 for 10 cycles.
2. Only req 2 valid (x5, 0xDEADBEEF) → req_ready = 0100 in cycle N; in N+1 wen0 = 1, wreg0 = 5, wdata0 = 0xDEADBEEF, wen1 = 0; rr_ptr = 3.
3. All four valid, distinct regs x1..x4, rr_ptr = 0 → cycle N grants 0,1 (ports 0,1 = x1,x2); cycle N+1 grants 2,3; rr_ptr wraps to 0.
4. Req 0 and req 1 both target x7, rr_ptr = 0 → only req 0 granted, conflict_cnt = 1; next cycle req 1 is granted to port 0 and x7 is written with req 1's data.
5. Req 3 targets x0 with data 0x12345678 and req 0 targets x9, rr_ptr = 3 → both granted; N+1: wen0 = 0, wen1 = 1, wreg1 = 9.
6. Reset asserted in the cycle after a handshake → wen0 = wen1 = 0 in the following cycle, rr_ptr = 0; after 2^CNTW conflicts without reset, conflict_cnt holds at 0xFFFF.
